// File: rtl/guitar_pkg.sv
// Shared widths, FSM state encoding and the sine-table generator for the
// guitar-tuner signal path.
package guitar_pkg;

   localparam int SAMPLE_W  = 8;
   localparam int CORR_W    = 10;
   localparam int LUT_DEPTH = 256;
   localparam int LUT_W     = 8;

   typedef enum logic [1:0] {
      ACC,
      MAG,
      OUT
   } state_t;

   // round(127*sin(2*pi*k/LUT_DEPTH)), evaluated only at elaboration time
   function automatic int sine_entry(input int k);
      real pi_c;
      real x;
      real term;
      real acc;
      pi_c = 3.14159265358979323846;
      x    = 2.0 * pi_c * $itor(k) / $itor(LUT_DEPTH);
      if (x > pi_c) x = x - 2.0 * pi_c;
      if (x > pi_c / 2.0) x = pi_c - x;
      else if (x < -pi_c / 2.0) x = -pi_c - x;
      term = x;
      acc  = x;
      for (int unsigned n = 1; n < 12; n++) begin
         term = -term * x * x / ((2.0 * $itor(n)) * (2.0 * $itor(n) + 1.0));
         acc  = acc + term;
      end
      acc = acc * 127.0;
      return (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(0.5 - acc);
   endfunction

endpackage

// File: rtl/note_correlator_if.sv
// Sample-in / correlation-out stream bundle of the note correlator.
interface note_correlator_if;
   import guitar_pkg::*;

   logic signed [SAMPLE_W-1:0] sample;
   logic                       sample_ready;
   logic [CORR_W-1:0]          correlation;
   logic                       correlation_valid;
   logic                       sample_dropped;

   modport master (
      output sample, sample_ready,
      input  correlation, correlation_valid, sample_dropped
   );

   modport slave (
      input  sample, sample_ready,
      output correlation, correlation_valid, sample_dropped
   );
endinterface

// File: rtl/sine_lut.sv
// Dual-read 256 x 8 signed sine ROM with registered outputs (1-cycle latency).
module sine_lut
   import guitar_pkg::*;
(
   input  logic                    clk,
   input  logic [7:0]              addr_a,
   input  logic [7:0]              addr_b,
   output logic signed [LUT_W-1:0] data_a,
   output logic signed [LUT_W-1:0] data_b
);

   logic signed [LUT_W-1:0] rom [LUT_DEPTH];

   for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
      localparam logic signed [LUT_W-1:0] V = LUT_W'(sine_entry(k));
      assign rom[k] = V;
   end

   always_ff @(posedge clk) begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
   end

endmodule

// File: rtl/note_correlator.sv
// Single-bin windowed DFT against a programmable reference tone; emits one
// saturated |I|+|Q| magnitude per WINDOW accepted samples.
module note_correlator
   import guitar_pkg::*;
#(
   parameter int          WINDOW    = 1024,
   parameter logic [15:0] PHASE_INC = 16'h0200,
   parameter int          SHIFT     = 16
) (
   input  logic             clk,
   input  logic             rst,
   note_correlator_if.slave bus
);

   localparam int CNT_W = $clog2(WINDOW);
   localparam int ACC_W = 16 + CNT_W;
   localparam int MAG_W = ACC_W + 1;
   localparam logic [CNT_W:0] LAST = (CNT_W + 1)'(WINDOW - 1);

   state_t state, state_next;

   logic [15:0]             phase;
   logic [7:0]              idx;
   logic signed [7:0]       s0, s1;
   logic signed [LUT_W-1:0] sinv, cosv;
   logic signed [15:0]      pi_q, pq_q;
   logic                    v0, v1, v2;
   logic signed [ACC_W-1:0] acc_i, acc_q;
   logic [CNT_W:0]          count;
   logic [MAG_W-1:0]        mag, mag_sum, mag_shift;
   logic [ACC_W-1:0]        abs_i, abs_q;
   logic [CORR_W-1:0]       corr_sat;
   logic                    busy, accept, window_done;

   sine_lut u_lut (
      .clk    (clk),
      .addr_a (idx),
      .addr_b (idx + 8'd64),
      .data_a (sinv),
      .data_b (cosv)
   );

   assign busy               = v0 | v1 | v2;
   assign accept             = bus.sample_ready && (state == ACC) && !busy;
   assign bus.sample_dropped = bus.sample_ready && !accept && !rst;
   assign window_done        = v2 && (count == LAST);

   always_comb begin
      state_next = state;
      case (state)
         ACC:     if (window_done) state_next = MAG;
         MAG:     state_next = OUT;
         OUT:     state_next = ACC;
         default: state_next = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ACC;
      else     state <= state_next;
   end

   always_comb begin
      abs_i     = acc_i[ACC_W-1] ? ACC_W'(-acc_i) : ACC_W'(acc_i);
      abs_q     = acc_q[ACC_W-1] ? ACC_W'(-acc_q) : ACC_W'(acc_q);
      mag_sum   = {1'b0, abs_i} + {1'b0, abs_q};
      mag_shift = mag >> SHIFT;
      corr_sat  = (mag_shift > MAG_W'(1023)) ? '1 : mag_shift[CORR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase                 <= '0;
         idx                   <= '0;
         s0                    <= '0;
         s1                    <= '0;
         pi_q                  <= '0;
         pq_q                  <= '0;
         v0                    <= 1'b0;
         v1                    <= 1'b0;
         v2                    <= 1'b0;
         acc_i                 <= '0;
         acc_q                 <= '0;
         count                 <= '0;
         mag                   <= '0;
         bus.correlation       <= '0;
         bus.correlation_valid <= 1'b0;
      end else begin
         v0                    <= accept;
         v1                    <= v0;
         v2                    <= v1;
         s1                    <= s0;
         bus.correlation_valid <= 1'b0;
         if (accept) begin
            s0    <= bus.sample;
            idx   <= phase[15:8];
            phase <= phase + PHASE_INC;
         end
         // s1 travels alongside the ROM's registered read of idx
         if (v1) begin
            pi_q <= 16'(s1) * 16'(cosv);
            pq_q <= 16'(s1) * 16'(sinv);
         end
         if (v2) begin
            acc_i <= acc_i + ACC_W'(pi_q);
            acc_q <= acc_q + ACC_W'(pq_q);
            count <= count + 1'b1;
         end
         if (state == MAG) mag <= mag_sum;
         if (state == OUT) begin
            bus.correlation       <= corr_sat;
            bus.correlation_valid <= 1'b1;
            acc_i                 <= '0;
            acc_q                 <= '0;
            count                 <= '0;
            phase                 <= '0;
         end
      end
   end

endmodule

// File: tb/tb_note_correlator.sv
// Directed and randomized checks of note_correlator (WINDOW=8, step 0x2000)
// with SHIFT=6 and a saturating SHIFT=0 instance against a DFT reference.
module tb_note_correlator;

   localparam int          WIN  = 8;
   localparam logic [15:0] STEP = 16'h2000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   note_correlator_if bus6 ();
   note_correlator_if bus0 ();

   note_correlator #(.WINDOW(WIN), .PHASE_INC(STEP), .SHIFT(6)) dut6 (
      .clk (clk),
      .rst (rst),
      .bus (bus6)
   );

   note_correlator #(.WINDOW(WIN), .PHASE_INC(STEP), .SHIFT(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   int vectors     = 0;
   int miscompares = 0;

   int lut [256];
   int cyc         = 0;
   int next_free   = 0;
   int valid_cycle = -1;
   int win_s [$];
   int pend6, pend0;
   int exp6, exp0;

   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
   endfunction

   function automatic int sat_shift(input longint m, input int sh);
      longint v;
      v = m >>> sh;
      return (v > 1023) ? 1023 : int'(v);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // Direct DFT of the completed window: sample k meets phase k*STEP.
   task automatic close_window();
      longint i_sum, q_sum, m;
      int     ix;
      i_sum = 0;
      q_sum = 0;
      for (int k = 0; k < WIN; k++) begin
         ix    = ((k * int'(STEP)) >> 8) % 256;
         i_sum += longint'(win_s[k] * lut[(ix + 64) % 256]);
         q_sum += longint'(win_s[k] * lut[ix]);
      end
      m     = ((i_sum < 0) ? -i_sum : i_sum) + ((q_sum < 0) ? -q_sum : q_sum);
      pend6 = sat_shift(m, 6);
      pend0 = sat_shift(m, 0);
      win_s.delete();
   endtask

   // One clock cycle: drive, check the drop strobe, cross the edge, check outputs.
   task automatic tick(input logic rdy, input int s, input logic r);
      logic acc_m, drop_m, valid_m;
      rst               = r;
      bus6.sample       = 8'(s);
      bus0.sample       = 8'(s);
      bus6.sample_ready = rdy;
      bus0.sample_ready = rdy;
      acc_m  = rdy && !r && (cyc >= next_free);
      drop_m = rdy && !r && !acc_m;
      #1;
      chk("dropped6", {31'b0, bus6.sample_dropped}, {31'b0, drop_m});
      chk("dropped0", {31'b0, bus0.sample_dropped}, {31'b0, drop_m});
      if (r) begin
         win_s.delete();
         valid_cycle = -1;
         next_free   = cyc + 1;
         exp6        = 0;
         exp0        = 0;
      end else if (acc_m) begin
         win_s.push_back(s);
         if (win_s.size() == WIN) begin
            close_window();
            valid_cycle = cyc + 6;
            next_free   = cyc + 6;
         end else begin
            next_free = cyc + 4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      valid_m = (cyc == valid_cycle);
      if (valid_m) begin
         exp6 = pend6;
         exp0 = pend0;
      end
      chk("valid6", {31'b0, bus6.correlation_valid}, {31'b0, valid_m});
      chk("valid0", {31'b0, bus0.correlation_valid}, {31'b0, valid_m});
      chk("corr6", 32'(bus6.correlation), 32'(exp6));
      chk("corr0", 32'(bus0.correlation), 32'(exp0));
   endtask

   task automatic send(input int s, input int gap);
      tick(1'b1, s, 1'b0);
      for (int g = 1; g < gap; g++) tick(1'b0, 0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int g = 0; g < n; g++) tick(1'b0, 0, 1'b0);
   endtask

   int cos_w [8] = '{127, 90, 0, -90, -127, -90, 0, 90};
   int sin_w [8] = '{0, 90, 127, 90, 0, -90, -127, -90};

   initial begin
      for (int k = 0; k < 256; k++)
         lut[k] = rnd(127.0 * $sin(2.0 * 3.14159265358979323846 * k / 256.0));
      exp6 = 0;
      exp0 = 0;

      // reset state
      for (int k = 0; k < 3; k++) tick(1'b0, 0, 1'b1);
      chk("reset_corr", 32'(bus6.correlation), 32'd0);

      // all-zero window
      for (int k = 0; k < WIN; k++) send(0, 10);
      chk("zero_window", 32'(bus6.correlation), 32'd0);

      // matched cosine, matched sine, DC
      for (int k = 0; k < WIN; k++) send(cos_w[k], 10);
      chk("cos_window", 32'(bus6.correlation), 32'd1010);
      chk("cos_saturated", 32'(bus0.correlation), 32'd1023);
      for (int k = 0; k < WIN; k++) send(sin_w[k], 10);
      chk("sin_window", 32'(bus6.correlation), 32'd1010);
      for (int k = 0; k < WIN; k++) send(100, 10);
      chk("dc_window", 32'(bus6.correlation), 32'd0);

      // second strobe 2 cycles after the first is dropped
      send(cos_w[0], 2);
      send(55, 10);
      for (int k = 1; k < WIN; k++) send(cos_w[k], 10);
      chk("drop_window", 32'(bus6.correlation), 32'd1010);

      // reset mid-window, then a fresh matched-cosine window
      for (int k = 0; k < 5; k++) send(sin_w[k], 10);
      tick(1'b0, 0, 1'b1);
      for (int k = 0; k < WIN; k++) send(cos_w[k], 10);
      chk("post_reset_window", 32'(bus6.correlation), 32'd1010);

      // randomized samples, spacing 3..12, sparse resets
      for (int w = 0; w < 24; w++) begin
         for (int k = 0; k < WIN + 2; k++) begin
            if ($urandom_range(0, 99) == 0) tick(1'b0, 0, 1'b1);
            send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(3, 12)));
         end
      end
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/note_correlator.md
Name: note_correlator

Overview:
- Producer side of the `correlation` / `correlation_valid` stream that drives the correlation bar display.
- Correlates incoming audio samples against a reference tone of programmable frequency, using single-bin windowed DFT: I/Q accumulation against a cos/sin LUT.
- Emits one 10-bit saturated magnitude per window of `WINDOW` samples.
- Sits between the audio sample source and the display-side correlation FIFO writer, all in the `clk` domain.

Parameters:
- `WINDOW`, 1024, samples per correlation window; power of 2, ≥ 4.
- `PHASE_INC`, 16'h0200, phase-accumulator step per sample; sets the reference frequency as `f = fs * PHASE_INC / 65536`.
- `SHIFT`, 16, right shift applied to the magnitude before 10-bit saturation.

Ports:
- `clk`  in  1  system clock, sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `sample`  in  8  signed two's-complement audio sample.
- `sample_ready`  in  1  one-cycle strobe: `sample` is valid this cycle.
- `correlation`  out  10  unsigned correlation magnitude; holds until the next result.
- `correlation_valid`  out  1  one-cycle strobe: `correlation` is new this cycle.
- `sample_dropped`  out  1  one-cycle strobe: a `sample_ready` arrived while busy and was discarded.

Behaviour:
- Reset (`rst` high at a `clk` edge) clears:
  - `correlation`=0, `correlation_valid`=0, `sample_dropped`=0;
  - I, Q accumulators=0, sample counter=0, phase=0;
  - pipeline valids=0; state=ACC.
- Reset takes priority over every other event, including mid-window and mid-pipeline. The partial window is discarded and no `correlation_valid` is produced for it.
- State machine:
  - ACC: accepts samples.
  - MAG: one cycle; computes `mag = |I| + |Q|`.
  - OUT: one cycle; drives the result, clears I, Q, counter and phase, then returns to ACC.
- Per-sample pipeline, stages accepted in ACC with pipeline idle:
  - P0 (edge of `sample_ready`): register the sample; LUT index `idx = phase[15:8]`; `phase <= phase + PHASE_INC` (16-bit wrap-around).
  - P1: registered LUT reads `sinv = lut[idx]`, `cosv = lut[idx+64 mod 256]`.
  - P2: products `pi = s*cosv`, `pq = s*sinv`, each signed 16-bit.
  - P3: `I += pi`, `Q += pq`; counter increments. When the counter reaches `WINDOW`, next state = MAG.
- Busy window and drops:
  - The pipeline is busy from P0 through P3 (4 cycles).
  - A `sample_ready` during busy, MAG or OUT is discarded and pulses `sample_dropped` that same cycle.
  - The minimum supported sample spacing is therefore 4 cycles; the audio rate is far below this.
- Widths and arithmetic:
  - LUT: 256 entries, 8-bit signed, `round(127*sin(2πk/256))`, range −127..127.
  - Accumulators: signed, `16 + log2(WINDOW)` bits (26 at default), so overflow is impossible.
  - `mag`: unsigned, one bit wider than an accumulator.
  - Absolute value of the most-negative accumulator value cannot occur, because the LUT is limited to ±127.
- OUT:
  - `correlation <= (mag >> SHIFT) > 1023 ? 1023 : (mag >> SHIFT)[9:0]`, with `correlation_valid` = 1 for exactly this cycle.
  - Latency is 2 cycles after the P3 of the `WINDOW`-th sample.
  - The next window begins with phase = 0, so results are deterministic per window.
- Back-pressure: the stream has none. The consumer may ignore a valid, for example when its FIFO is full; the producer never stalls.

Decomposition:
- Shared package `guitar_pkg`:
  - `SAMPLE_W=8`, `CORR_W=10`, `LUT_DEPTH=256`, `LUT_W=8`;
  - state encoding `ACC`/`MAG`/`OUT`.
- One sub-module `sine_lut`:
  - synchronous dual-read ROM, two address ports, registered outputs, 1-cycle latency;
  - contents generated from the formula above (initial block or `.coe`).

Test Plan (`WINDOW`=8, `PHASE_INC`=16'h2000, `SHIFT`=6, `sample_ready` every 10 cycles unless stated):
- Eight samples of 0 → one `correlation_valid` pulse 2 cycles after the 8th P3, `correlation`=0; none before.
- Samples 127,90,0,−90,−127,−90,0,90 (matched cosine) → I=64658, Q=0, `correlation`=1010, exactly one valid pulse.
- Samples 0,90,127,90,0,−90,−127,−90 (matched sine) → I=0, Q=64658, `correlation`=1010.
- Eight samples of constant 100 (DC, off-bin) → I=Q=0, `correlation`=0.
- `SHIFT`=0, matched cosine input → `mag`=64658 > 1023, `correlation`=1023 (saturated).
- Two `sample_ready` strobes 2 cycles apart → second dropped, `sample_dropped` pulses once, and the window completes only after 8 accepted samples.
- `rst` asserted for 1 cycle after 5 samples, then 8 matched-cosine samples → no valid before the 8th post-reset sample; result = 1010.
